// File: rtl/fdivsqrt_r4_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fdivsqrt_r4_iter: radix-4 div/sqrt iteration sequencer and residual/root    |
// | register file. Rev 1.0                                                      |
// +----------------------------------------------------------------------------+
module fdivsqrt_r4_iter #(
  parameter int DIVb  = 56,
  parameter int STEPW = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              InValid,
  output logic              InReady,
  input  logic              SqrtIn,
  input  logic [DIVb+3:0]   X,
  input  logic [DIVb+3:0]   DIn,
  input  logic [DIVb:0]     U0,
  input  logic [DIVb:0]     UM0,
  input  logic [STEPW-1:0]  NSteps,
  input  logic              Abort,
  output logic [DIVb+3:0]   D,
  output logic [DIVb+3:0]   DBar,
  output logic [DIVb+3:0]   D2,
  output logic [DIVb+3:0]   DBar2,
  output logic [DIVb+3:0]   WS,
  output logic [DIVb+3:0]   WC,
  output logic [DIVb:0]     U,
  output logic [DIVb:0]     UM,
  output logic [DIVb+1:0]   C,
  output logic              SqrtE,
  input  logic [DIVb+3:0]   WSNext,
  input  logic [DIVb+3:0]   WCNext,
  input  logic [DIVb:0]     UNext,
  input  logic [DIVb:0]     UMNext,
  input  logic [DIVb+1:0]   CNext,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              RemNeg,
  output logic              RemZero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DIVb+3:0]    ws_q, ws_d, wc_q, wc_d, d_q, d_d;
  logic [DIVb:0]      u_q, u_d, um_q, um_d;
  logic [DIVb+1:0]    c_q, c_d;
  logic [STEPW-1:0]   cnt_q, cnt_d;
  logic               sqrt_q, sqrt_d;
  logic               rdy_q, rdy_d;
  logic [DIVb+3:0]    rem_sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ws_q    <= '0;
      wc_q    <= '0;
      u_q     <= '0;
      um_q    <= '0;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      sqrt_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ws_q    <= ws_d;
      wc_q    <= wc_d;
      u_q     <= u_d;
      um_q    <= um_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      sqrt_q  <= sqrt_d;
      rdy_q   <= rdy_d;
    end
  end

  // Stage inputs are only sampled in BUSY, so X from the stage cannot leak in.
  always_comb begin
    state_d = state_q;
    ws_d    = ws_q;
    wc_d    = wc_q;
    u_d     = u_q;
    um_d    = um_q;
    c_d     = c_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    sqrt_d  = sqrt_q;
    rdy_d   = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!Abort && InValid && rdy_q) begin
          ws_d    = X;
          wc_d    = '0;
          u_d     = U0;
          um_d    = UM0;
          c_d     = '0;
          d_d     = DIn;
          sqrt_d  = SqrtIn;
          cnt_d   = NSteps;
          state_d = (NSteps != '0) ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        if (!Abort) begin
          ws_d  = WSNext;
          wc_d  = WCNext;
          u_d   = UNext;
          um_d  = UMNext;
          c_d   = CNext;
          cnt_d = cnt_q - STEPW'(1);
          if (cnt_q <= STEPW'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (OutReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (Abort) state_d = S_IDLE;
  end

  assign rem_sum  = ws_q + wc_q;
  assign OutValid = (state_q == S_DONE);
  assign InReady  = rdy_q && (state_q == S_IDLE);
  assign RemNeg   = OutValid && rem_sum[DIVb+3];
  assign RemZero  = OutValid && (rem_sum == '0);

  assign D     = d_q;
  assign DBar  = ~d_q;
  assign D2    = {d_q[DIVb+2:0], 1'b0};
  assign DBar2 = ~{d_q[DIVb+2:0], 1'b0};
  assign WS    = ws_q;
  assign WC    = wc_q;
  assign U     = u_q;
  assign UM    = um_q;
  assign C     = c_q;
  assign SqrtE = sqrt_q;

endmodule
`default_nettype wire

// File: tb/tb_fdivsqrt_r4_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fdivsqrt_r4_iter: directed bench with an exact radix-4 stage model.      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_fdivsqrt_r4_iter;
  localparam int DIVb  = 56;
  localparam int STEPW = 6;
  localparam int W  = DIVb + 4;
  localparam int UW = DIVb + 1;
  localparam int CW = DIVb + 2;

  logic clk = 1'b0;
  logic reset_n;
  logic InValid, InReady, SqrtIn, Abort, OutValid, OutReady, RemNeg, RemZero, SqrtE;
  logic [W-1:0]  X, DIn, D, DBar, D2, DBar2, WS, WC, WSNext, WCNext;
  logic [UW-1:0] U0, UM0, U, UM, UNext, UMNext;
  logic [CW-1:0] C, CNext;
  logic [STEPW-1:0] NSteps;

  int errors = 0;
  int checks = 0;

  fdivsqrt_r4_iter #(.DIVb(DIVb), .STEPW(STEPW)) dut (
    .clk(clk), .reset_n(reset_n), .InValid(InValid), .InReady(InReady), .SqrtIn(SqrtIn),
    .X(X), .DIn(DIn), .U0(U0), .UM0(UM0), .NSteps(NSteps), .Abort(Abort),
    .D(D), .DBar(DBar), .D2(D2), .DBar2(DBar2), .WS(WS), .WC(WC), .U(U), .UM(UM),
    .C(C), .SqrtE(SqrtE), .WSNext(WSNext), .WCNext(WCNext), .UNext(UNext),
    .UMNext(UMNext), .CNext(CNext), .OutValid(OutValid), .OutReady(OutReady),
    .RemNeg(RemNeg), .RemZero(RemZero)
  );

  always #5 clk = ~clk;

  // Exact (non-redundant) radix-4 stage; the step index is recovered from C.
  always_comb begin
    logic [W-1:0] s;
    longint w, dl, ul, wt, best, cand, un, um_n;
    int j, pos, qb;
    int qs [5];
    qs = '{0, 1, -1, 2, -2};
    s  = WS + WC;
    w  = longint'($signed(s));
    dl = longint'({4'b0, D});
    ul = longint'({7'b0, U});
    j  = $countones(C) / 2;
    pos = DIVb - 2 * (j + 1);
    wt = (pos >= 0) ? (64'sd1 <<< pos) : 64'sd0;
    best = 4 * w;
    qb = 0;
    for (int k = 0; k < 5; k++) begin
      if (SqrtE) cand = 4 * w - 2 * longint'(qs[k]) * ul - longint'(qs[k] * qs[k]) * wt;
      else       cand = 4 * w - longint'(qs[k]) * dl;
      if (((cand < 0) ? -cand : cand) < ((best < 0) ? -best : best)) begin
        best = cand;
        qb   = qs[k];
      end
    end
    un     = ul + longint'(qb) * wt;
    um_n   = un - wt;
    WSNext = best[W-1:0];
    WCNext = '0;
    UNext  = un[UW-1:0];
    UMNext = um_n[UW-1:0];
    CNext  = {2'b11, C[CW-1:2]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic sq, input logic [W-1:0] x, input logic [W-1:0] d,
                       input logic [UW-1:0] u0, input logic [UW-1:0] um0,
                       input logic [STEPW-1:0] n);
    SqrtIn = sq; X = x; DIn = d; U0 = u0; UM0 = um0; NSteps = n; InValid = 1'b1;
    tick();
    InValid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!OutValid && n < 100) begin
      tick();
      n++;
    end
  endtask

  localparam logic [W-1:0]  ONE_Q4     = 60'h100_0000_0000_0000;
  localparam logic [W-1:0]  QUARTER_Q4 = 60'h040_0000_0000_0000;
  localparam logic [W-1:0]  NEGHALF_Q4 = 60'hF80_0000_0000_0000;
  localparam logic [UW-1:0] QUARTER_U  = 57'h40_0000_0000_0000;
  localparam logic [UW-1:0] HALF_U     = 57'h80_0000_0000_0000;
  localparam logic [UW-1:0] PAT_U0     = 57'h1_2345_6789_ABCD;
  localparam logic [UW-1:0] PAT_UM0    = 57'h1_2345_6789_ABCC;
  localparam logic [CW-1:0] C_FULL     = 58'h3FF_FFFF_FFFF_FFFF;

  initial begin
    int n;
    logic [W-1:0]  ws_s;
    logic [UW-1:0] u_s;
    logic [CW-1:0] c_s;
    reset_n = 1'b0; InValid = 1'b0; SqrtIn = 1'b0; Abort = 1'b0; OutReady = 1'b0;
    X = '0; DIn = '0; U0 = '0; UM0 = '0; NSteps = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_inready", InReady, 0);
    check("rst_outvalid", OutValid, 0);
    check("rst_ws", WS, 0);
    check("rst_d", D, 0);
    reset_n = 1'b1;
    tick();
    check("rst_inready_after", InReady, 1);

    // Divide 0.25 / 1.0
    start(1'b0, QUARTER_Q4, ONE_Q4, '0, '0, 6'd29);
    check("div_load_ws", WS, QUARTER_Q4);
    check("div_load_c", C, 0);
    check("div_load_inready", InReady, 0);
    check("div_d2", D2, 60'h200_0000_0000_0000);
    check("div_dbar", DBar, 60'hEFF_FFFF_FFFF_FFFF);
    check("div_dbar2", DBar2, 60'hDFF_FFFF_FFFF_FFFF);
    wait_valid(n);
    check("div_latency", n, 30);
    check("div_u", U, QUARTER_U);
    check("div_remzero", RemZero, 1);
    check("div_remneg", RemNeg, 0);
    check("div_c_full", C, C_FULL);
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    check("div_exit_outvalid", OutValid, 0);
    check("div_exit_inready", InReady, 1);

    // NSteps = 0 with negative residual, then backpressure in DONE
    start(1'b0, NEGHALF_Q4, ONE_Q4, PAT_U0, PAT_UM0, 6'd0);
    check("n0_outvalid", OutValid, 1);
    check("n0_ws", WS, NEGHALF_Q4);
    check("n0_remneg", RemNeg, 1);
    check("n0_remzero", RemZero, 0);
    check("n0_u", U, PAT_U0);
    check("n0_um", UM, PAT_UM0);
    InValid = 1'b1; X = QUARTER_Q4;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_outvalid", OutValid, 1);
      check("bp_inready", InReady, 0);
      check("bp_ws", WS, NEGHALF_Q4);
      check("bp_u", U, PAT_U0);
    end
    InValid = 1'b0; OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    check("bp_exit_outvalid", OutValid, 0);
    check("bp_exit_inready", InReady, 1);

    // Abort in third BUSY cycle with InValid high
    start(1'b0, QUARTER_Q4, ONE_Q4, '0, '0, 6'd20);
    tick();
    tick();
    ws_s = WS; u_s = U; c_s = C;
    Abort = 1'b1; InValid = 1'b1; X = NEGHALF_Q4; NSteps = 6'd0;
    tick();
    check("abort_outvalid", OutValid, 0);
    check("abort_inready", InReady, 1);
    check("abort_ws", WS, ws_s);
    check("abort_u", U, u_s);
    check("abort_c", C, c_s);
    tick();
    check("abort_idle_noload_ws", WS, ws_s);
    check("abort_idle_outvalid", OutValid, 0);
    Abort = 1'b0; InValid = 1'b0;

    // Square root of 0.25
    start(1'b1, QUARTER_Q4, ONE_Q4, '0, '0, 6'd29);
    check("sqrt_load_c", C, 0);
    check("sqrt_sqrte", SqrtE, 1);
    wait_valid(n);
    check("sqrt_latency", n, 30);
    check("sqrt_u", U, HALF_U);
    check("sqrt_remzero", RemZero, 1);
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;

    // Reset mid-BUSY with cnt = 10
    start(1'b1, QUARTER_Q4, ONE_Q4, '0, '0, 6'd20);
    repeat (10) tick();
    check("pre_rst_outvalid", OutValid, 0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_ws", WS, 0);
    check("midrst_u", U, 0);
    check("midrst_c", C, 0);
    check("midrst_d", D, 0);
    check("midrst_sqrte", SqrtE, 0);
    check("midrst_inready", InReady, 0);
    check("midrst_outvalid", OutValid, 0);
    #1 reset_n = 1'b1;
    tick();
    check("midrst_release_inready", InReady, 1);
    check("midrst_release_outvalid", OutValid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
